controller_reader: RTL and testbench
====================================

Name: controller_reader

Overview:
- Polls the two game-pad shift registers over the shared latch/clock lines and deserialises their active-low serial data.
- Presents the result as two registered, active-high button bytes for the CPU memory-mapped I/O block.
- A one-cycle `start` pulse launches one poll; the frame-timing logic issues it once per vblank.
- Bit order is fixed by the pad: {a,b,select,start,up,down,left,right}, a shifted out first.

Parameters:
- LATCH_CYCLES, 12, system-clock cycles the pad latch is held high (legal ≥ 1).
- CLK_HALF, 6, system-clock cycles per half period of the pad clock (legal ≥ 3; elaboration-time assertion).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- start  in  1  request one poll; honoured only in IDLE
- data_1_B  in  1  serial data from pad 1, active-low, asynchronous to clk
- data_2_B  in  1  serial data from pad 2, active-low, asynchronous to clk
- pad_latch  out  1  latch line, shared by both pads
- pad_clk  out  1  shift clock, shared by both pads; the pads shift on its rising edge
- busy  out  1  high whenever state ≠ IDLE
- buttons_1  out  8  pad 1 state, active-high; bit 7 = a, bit 0 = right
- buttons_2  out  8  pad 2 state, same format
- valid  out  1  one-cycle pulse when buttons_1/2 update

Behaviour:
- Reset values: pad_latch=0, pad_clk=0, busy=0, valid=0, buttons_1=buttons_2=8'h00.
  - Internal: shift registers 0, bit index 0, counter 0, state IDLE.
  - Both synchroniser stages reset to 1 (line idle = no press).
- Input sync: each data_x_B passes through a 2-flop synchroniser before any use.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE. All outputs are registered (no combinational paths).
- IDLE:
  - pad_latch=0, pad_clk=0.
  - `start`=1 → LATCH; counter cleared.
- LATCH:
  - pad_latch=1 for exactly LATCH_CYCLES cycles.
  - Then → LOW; bit index=0.
- LOW:
  - pad_clk=0 for CLK_HALF cycles.
  - On the last LOW cycle, each shift register loads {sr[6:0], ~data_sync}, inverting to active-high.
  - Then → HIGH.
- HIGH:
  - pad_clk=1 for CLK_HALF cycles.
  - At the end: if bit index == 7 → DONE, else increment bit index → LOW.
  - A full poll produces exactly 8 pad_clk rising edges; the 8th is harmless.
- DONE:
  - Lasts one cycle.
  - buttons_1/2 are loaded from the shift registers on entry and are visible during DONE, together with valid=1.
  - Then → IDLE.
- Latency: with `start` sampled high at edge 0, valid is high in cycle 1 + LATCH_CYCLES + 16·CLK_HALF. Defaults give cycle 109.
- buttons_1/2 hold their value between polls; they change only in the DONE cycle.
- `start` while busy (including DONE) is ignored, not queued.
- rst asserted mid-poll returns everything to reset values immediately.
  - pad_latch and pad_clk drop asynchronously.
  - buttons are cleared to 00 and the partial result is discarded.
  - After rst deasserts, the FSM is IDLE; a new `start` is required.
- Counters are sized $clog2 of max(LATCH_CYCLES, CLK_HALF)+1. Bit index is 3 bits and never wraps past 7.

Decomposition:
- Shared package controller_pkg:
  - state enum {IDLE, LATCH, LOW, HIGH, DONE}.
  - Button bit-index constants BTN_A=7, BTN_B=6, BTN_SELECT=5, BTN_START=4, BTN_UP=3, BTN_DOWN=2, BTN_LEFT=1, BTN_RIGHT=0.
- Sub-module sync_2ff:
  - Parameterised reset value; instanced once per data line.
- FSM, counters and both shift registers stay in controller_reader.

Test Plan:
- Release reset with pads at buttons_B=8'hFF, pulse `start` → valid in cycle 109, buttons_1=buttons_2=8'h00, busy low the following cycle.
- Pad 1 buttons_B=8'b0111_1110, pad 2=8'b1110_1111 → buttons_1=8'h81 (a, right), buttons_2=8'h10 (start).
- Waveform check on one poll:
  - pad_latch high for exactly 12 cycles.
  - Then exactly 8 pad_clk rising edges, each high 6 and low 6 cycles.
  - pad_latch and pad_clk never high simultaneously.
- `start` re-pulsed at cycles 5, 50 and 109 of a poll → ignored; exactly one valid pulse; no extra latch.
- Assert rst at cycle 60 of a poll with pad 1=8'h00 → pad_latch=pad_clk=0 and buttons=00 at once; a new poll then yields buttons_1=8'hFF.
- Change pad buttons_B from 8'hFE to 8'h7F at cycle 40, after the latch falls → result still reflects 8'hFE (buttons_1=8'h01); the next poll reflects 8'h7F (8'h80).

Source files
------------

// File: rtl/controller_pkg.sv
// controller_pkg: shared state encoding and button bit positions for the pad reader.
package controller_pkg;
    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;
endpackage

// File: rtl/controller_reader_if.sv
// controller_reader_if: poll request, pad lines and button results of the pad reader.
interface controller_reader_if;
    logic       start;
    logic       data_1_B;
    logic       data_2_B;
    logic       pad_latch;
    logic       pad_clk;
    logic       busy;
    logic [7:0] buttons_1;
    logic [7:0] buttons_2;
    logic       valid;
    modport master (
        input  start, data_1_B, data_2_B,
        output pad_latch, pad_clk, busy, buttons_1, buttons_2, valid
    );
    modport slave (
        output start, data_1_B, data_2_B,
        input  pad_latch, pad_clk, busy, buttons_1, buttons_2, valid
    );
endinterface

// File: rtl/controller_reader_sync_2ff.sv
// sync_2ff: two-flop synchroniser with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, meta} <= {2{RST_VAL}};
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/controller_reader.sv
// controller_reader: polls two serial game pads and publishes active-high button bytes.
module controller_reader
    import controller_pkg::*;
#(
    parameter int LATCH_CYCLES = 12,
    parameter int CLK_HALF     = 6
) (
    input  logic clk,
    input  logic rst,
    controller_reader_if.master bus
);
    localparam int CMAX = (LATCH_CYCLES > CLK_HALF) ? LATCH_CYCLES : CLK_HALF;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] L_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] H_LAST = CW'(CLK_HALF - 1);

    if (CLK_HALF < 3) begin : g_bad_half
        $error("CLK_HALF must be at least 3");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sr_1, sr_2;
    logic          d_1, d_2;

    // idle line is high, so a freshly reset synchroniser reads as "not pressed"
    sync_2ff #(.RST_VAL(1'b1)) u_sync_1 (.clk(clk), .rst(rst), .d(bus.data_1_B), .q(d_1));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_2 (.clk(clk), .rst(rst), .d(bus.data_2_B), .q(d_2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            sr_1          <= '0;
            sr_2          <= '0;
            bus.pad_latch <= 1'b0;
            bus.pad_clk   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.valid     <= 1'b0;
            bus.buttons_1 <= '0;
            bus.buttons_2 <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state         <= LATCH;
                    cnt           <= '0;
                    bus.pad_latch <= 1'b1;
                    bus.busy      <= 1'b1;
                end
                LATCH: if (cnt == L_LAST) begin
                    state         <= LOW;
                    cnt           <= '0;
                    idx           <= '0;
                    bus.pad_latch <= 1'b0;
                end else cnt <= cnt + 1'b1;
                // sample on the last low cycle, just before the pad shifts on the rising edge
                LOW: if (cnt == H_LAST) begin
                    state       <= HIGH;
                    cnt         <= '0;
                    bus.pad_clk <= 1'b1;
                    sr_1        <= {sr_1[6:0], ~d_1};
                    sr_2        <= {sr_2[6:0], ~d_2};
                end else cnt <= cnt + 1'b1;
                HIGH: if (cnt == H_LAST) begin
                    cnt         <= '0;
                    bus.pad_clk <= 1'b0;
                    if (idx == 3'd7) begin
                        state         <= DONE;
                        bus.valid     <= 1'b1;
                        bus.buttons_1 <= sr_1;
                        bus.buttons_2 <= sr_2;
                    end else begin
                        state <= LOW;
                        idx   <= idx + 3'd1;
                    end
                end else cnt <= cnt + 1'b1;
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_controller_reader.sv
// tb_controller_reader: scoreboard bench with a behavioural model of two serial pads.
module tb_controller_reader;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] btn_1 = 8'hFF, btn_2 = 8'hFF;
    logic [7:0] pad_sr_1 = 8'hFF, pad_sr_2 = 8'hFF;
    int checks = 0, fails = 0, cyc = 0;
    logic [15:0] sb[$];

    controller_reader_if bus();
    controller_reader dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // pad: parallel load while latched, shift toward the output on each pad_clk rise
    assign bus.data_1_B = pad_sr_1[7];
    assign bus.data_2_B = pad_sr_2[7];
    always @(posedge bus.pad_latch or posedge bus.pad_clk) begin
        if (bus.pad_latch) begin
            pad_sr_1 <= btn_1;
            pad_sr_2 <= btn_2;
        end else begin
            pad_sr_1 <= {pad_sr_1[6:0], 1'b1};
            pad_sr_2 <= {pad_sr_2[6:0], 1'b1};
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic launch();
        @(negedge clk);
        bus.start = 1'b1;
        sb.push_back({~btn_1, ~btn_2});
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
    endtask

    task automatic run_to_valid();
        while (!bus.valid && cyc < 400) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.pad_latch, bus.pad_clk, bus.busy, bus.valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl got latch/clk/busy/valid=%b exp 0000",
                     {bus.pad_latch, bus.pad_clk, bus.busy, bus.valid});
        end
        checks++;
        if ({bus.buttons_1, bus.buttons_2} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_buttons got %h exp 0000", {bus.buttons_1, bus.buttons_2});
        end
        rst = 1'b0;
    endtask

    task automatic test_first_poll();
        logic [15:0] e;
        btn_1 = 8'hFF;
        btn_2 = 8'hFF;
        launch();
        checks++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL first_busy got %b exp 1", bus.busy);
        end
        run_to_valid();
        checks++;
        if (bus.valid !== 1'b1 || cyc != 109) begin
            fails++;
            $display("FAIL first_latency got valid=%b cycle=%0d exp valid=1 cycle=109", bus.valid, cyc);
        end
        e = sb.pop_front();
        checks++;
        if ({bus.buttons_1, bus.buttons_2} !== e) begin
            fails++;
            $display("FAIL first_buttons got %h exp %h", {bus.buttons_1, bus.buttons_2}, e);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            fails++;
            $display("FAIL first_after got busy=%b valid=%b exp 0 0", bus.busy, bus.valid);
        end
    endtask

    task automatic test_pattern();
        logic [15:0] e;
        btn_1 = 8'b0111_1110;
        btn_2 = 8'b1110_1111;
        launch();
        run_to_valid();
        e = sb.pop_front();
        checks++;
        if (bus.valid !== 1'b1 || {bus.buttons_1, bus.buttons_2} !== e) begin
            fails++;
            $display("FAIL pattern_buttons got valid=%b %h exp valid=1 %h",
                     bus.valid, {bus.buttons_1, bus.buttons_2}, e);
        end
    endtask

    task automatic test_waveform();
        int lat = 0, rises = 0, bad_hi = 0, bad_lo = 0, overlap = 0, run = 0;
        logic prev = 1'b0, done = 1'b0;
        logic [15:0] e;
        btn_1 = 8'h3C;
        btn_2 = 8'hA5;
        launch();
        for (int k = 0; k < 300 && !done; k++) begin
            if (bus.pad_latch && bus.pad_clk) overlap++;
            if (bus.pad_latch) begin
                lat++;
                run = 0;
            end else if (bus.pad_clk != prev) begin
                if (bus.pad_clk) begin
                    rises++;
                    if (run != 6) bad_lo++;
                end else if (run != 6) bad_hi++;
                run = 1;
            end else run++;
            prev = bus.pad_clk;
            if (bus.valid) done = 1'b1;
            else tick();
        end
        checks++;
        if (lat != 12) begin
            fails++;
            $display("FAIL wave_latch got %0d cycles exp 12", lat);
        end
        checks++;
        if (rises != 8) begin
            fails++;
            $display("FAIL wave_rises got %0d exp 8", rises);
        end
        checks++;
        if (bad_hi != 0 || bad_lo != 0) begin
            fails++;
            $display("FAIL wave_halves got bad_hi=%0d bad_lo=%0d exp 0 0", bad_hi, bad_lo);
        end
        checks++;
        if (overlap != 0) begin
            fails++;
            $display("FAIL wave_overlap got %0d exp 0", overlap);
        end
        e = sb.pop_front();
        checks++;
        if (!done || {bus.buttons_1, bus.buttons_2} !== e) begin
            fails++;
            $display("FAIL wave_buttons got valid=%b %h exp valid=1 %h",
                     done, {bus.buttons_1, bus.buttons_2}, e);
        end
    endtask

    task automatic test_restart();
        int vcnt = 0, vcyc = 0, lrise = 0;
        logic prev = 1'b0;
        logic [15:0] got = '0, e;
        btn_1 = 8'h5A;
        btn_2 = 8'hC3;
        launch();
        while (cyc < 170) begin
            bus.start = (cyc == 5 || cyc == 50 || cyc == 109);
            if (bus.pad_latch && !prev) lrise++;
            prev = bus.pad_latch;
            if (bus.valid) begin
                vcnt++;
                vcyc = cyc;
                got = {bus.buttons_1, bus.buttons_2};
            end
            tick();
        end
        bus.start = 1'b0;
        checks++;
        if (vcnt != 1 || vcyc != 109) begin
            fails++;
            $display("FAIL restart_valid got %0d pulses at cycle %0d exp 1 at 109", vcnt, vcyc);
        end
        checks++;
        if (lrise != 1) begin
            fails++;
            $display("FAIL restart_latch got %0d latch pulses exp 1", lrise);
        end
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            fails++;
            $display("FAIL restart_buttons got %h exp %h", got, e);
        end
    endtask

    task automatic test_reset_mid();
        int vcnt = 0;
        logic [15:0] e;
        btn_1 = 8'h00;
        btn_2 = 8'hFF;
        launch();
        while (cyc < 60) tick();
        checks++;
        if (bus.pad_clk !== 1'b1 || bus.buttons_1 === 8'h00) begin
            fails++;
            $display("FAIL midrst_pre got pad_clk=%b buttons_1=%h exp pad_clk=1 buttons_1 nonzero",
                     bus.pad_clk, bus.buttons_1);
        end
        rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if ({bus.pad_latch, bus.pad_clk, bus.busy} !== 3'b000) begin
            fails++;
            $display("FAIL midrst_lines got latch/clk/busy=%b exp 000",
                     {bus.pad_latch, bus.pad_clk, bus.busy});
        end
        checks++;
        if ({bus.buttons_1, bus.buttons_2} !== 16'h0000) begin
            fails++;
            $display("FAIL midrst_buttons got %h exp 0000", {bus.buttons_1, bus.buttons_2});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (150) begin
            if (bus.valid || bus.pad_latch) vcnt++;
            tick();
        end
        checks++;
        if (vcnt != 0) begin
            fails++;
            $display("FAIL midrst_idle got %0d active cycles exp 0", vcnt);
        end
        launch();
        run_to_valid();
        e = sb.pop_front();
        checks++;
        if (bus.valid !== 1'b1 || {bus.buttons_1, bus.buttons_2} !== e) begin
            fails++;
            $display("FAIL midrst_repoll got valid=%b %h exp valid=1 %h",
                     bus.valid, {bus.buttons_1, bus.buttons_2}, e);
        end
    endtask

    task automatic test_change();
        logic [15:0] e;
        btn_1 = 8'hFE;
        btn_2 = 8'hFF;
        launch();
        while (cyc < 40) tick();
        btn_1 = 8'h7F;
        run_to_valid();
        e = sb.pop_front();
        checks++;
        if (bus.valid !== 1'b1 || {bus.buttons_1, bus.buttons_2} !== e) begin
            fails++;
            $display("FAIL change_old got valid=%b %h exp valid=1 %h",
                     bus.valid, {bus.buttons_1, bus.buttons_2}, e);
        end
        tick();
        launch();
        run_to_valid();
        e = sb.pop_front();
        checks++;
        if (bus.valid !== 1'b1 || {bus.buttons_1, bus.buttons_2} !== e) begin
            fails++;
            $display("FAIL change_new got valid=%b %h exp valid=1 %h",
                     bus.valid, {bus.buttons_1, bus.buttons_2}, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_poll();
        test_pattern();
        test_waveform();
        test_restart();
        test_reset_mid();
        test_change();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
